// File: rtl/rv32i_trace_pkg.sv
// rv32i_trace_pkg
// Shared definitions for the writeback trace FIFO: Wishbone register
// offsets (word index, adr[3:2]), CTRL/STATUS bit positions and the
// stored CTRL register layout.
package rv32i_trace_pkg;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] DATA_OFS   = 2'd2;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int CTRL_CLR_BIT   = 3;

    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    // Stored CTRL bits; clr is a strobe and is never held.
    typedef struct packed {
        logic ie;
        logic mode;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with binary pointers one bit wider than the address,
// so full and empty are distinguished by the pointer difference.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   clr          flush; wins over push and pop
//   rdata        head entry, combinational
//   count        number of stored entries
//   full, empty  status flags
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count = wptr_q - rptr_q;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only if the head leaves this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rv32i_wb_trace_fifo.sv
// rv32i_wb_trace_fifo
// Samples the core writeback bus and queues the samples for the
// management SoC, which drains them over a Wishbone classic slave.
// Ports:
//   clk, RN              clock, asynchronous active-low reset
//   WB_OUT               core writeback value
//   wbs_*_i              Wishbone request (sel ignored, full-word access)
//   wbs_ack_o            one-cycle acknowledge, one cycle after accept
//   wbs_dat_o            read data, valid only while ack is high
//   irq_o                registered CTRL.ie & !empty
module rv32i_wb_trace_fifo
    import rv32i_trace_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter int          WIDTH    = 16,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             clk,
    input  logic             RN,
    input  logic [WIDTH-1:0] WB_OUT,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq_o
);
    localparam int AW = $clog2(DEPTH);

    ctrl_t            ctrl_q, ctrl_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] prev_q;
    logic             ack_q, irq_q;
    logic [1:0]       req_adr_q;
    logic             req_we_q;
    logic [31:0]      req_dat_q;

    logic             accept, wr_commit, rd_commit;
    logic             push_req, pop, clr;
    logic [WIDTH-1:0] fifo_rdata;
    logic [AW:0]      fifo_count;
    logic             fifo_full, fifo_empty;
    logic [31:0]      rd_mux;

    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign accept    = wbs_stb_i & wbs_cyc_i & ~ack_q
                     & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // Side effects commit on the edge that ends the ack cycle.
    assign wr_commit = ack_q & req_we_q;
    assign rd_commit = ack_q & ~req_we_q;

    assign clr      = wr_commit & (req_adr_q == CTRL_OFS) & req_dat_q[CTRL_CLR_BIT];
    assign pop      = rd_commit & (req_adr_q == DATA_OFS);
    assign push_req = ctrl_q.en & (ctrl_q.mode | (WB_OUT != prev_q));

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (RN),
        .push  (push_req),
        .pop   (pop),
        .clr   (clr),
        .wdata (WB_OUT),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_commit && req_adr_q == CTRL_OFS) begin
            ctrl_d = ctrl_t'(req_dat_q[2:0]);
        end
        // A new overflow outranks a same-cycle W1C so no drop goes unreported.
        ovf_d = ovf_q;
        if (wr_commit && req_adr_q == STATUS_OFS && req_dat_q[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop && !clr) ovf_d = 1'b1;
        if (clr) ovf_d = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        case (req_adr_q)
            CTRL_OFS:   rd_mux = 32'(ctrl_q);
            STATUS_OFS: begin
                rd_mux[7:0]            = 8'(fifo_count);
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[STAT_OVF_BIT]   = ovf_q;
            end
            DATA_OFS:   rd_mux = fifo_empty ? 32'h0 : 32'(fifo_rdata);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            req_adr_q <= '0;
            req_we_q  <= 1'b0;
            req_dat_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            prev_q <= WB_OUT;
            ack_q  <= accept;
            irq_q  <= ctrl_q.ie & ~fifo_empty;
            if (accept) begin
                req_adr_q <= wbs_adr_i[3:2];
                req_we_q  <= wbs_we_i;
                req_dat_q <= wbs_dat_i;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rd_commit ? rd_mux : 32'h0;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_rv32i_wb_trace_fifo.sv
module tb_rv32i_wb_trace_fifo;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_DATA   = 32'h3000_0008;
    localparam logic [31:0] A_RSVD   = 32'h3000_000C;
    localparam logic [31:0] A_OTHER  = 32'h3000_0010;

    logic        clk = 1'b0;
    logic        RN = 1'b0;
    logic [15:0] WB_OUT = '0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o, irq_o;
    logic [31:0] wbs_dat_o;

    int n_cmp = 0;
    int n_bad = 0;

    rv32i_wb_trace_fifo dut (
        .clk       (clk),
        .RN        (RN),
        .WB_OUT    (WB_OUT),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access; returns just after the commit edge when acked.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;
        acked = 1'b0; rdat = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        if (acked) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wb_wr(input string tag, input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] r;
        logic        a;
        wb_xfer(1'b1, adr, d, r, a);
        chk({tag, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic wb_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic        a;
        wb_xfer(1'b0, adr, '0, r, a);
        chk({tag, "_ack"}, 32'(a), 32'd1);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic        a;

        repeat (3) @(negedge clk);
        RN = 1'b1;

        // Reset state
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        wb_rd("rst_status", A_STATUS, 32'h100);
        wb_rd("rst_data_empty", A_DATA, 32'h0);
        wb_rd("rst_status_nopop", A_STATUS, 32'h100);
        wb_rd("rst_ctrl", A_CTRL, 32'h0);
        wb_wr("rsvd_wr", A_RSVD, 32'hFFFF_FFFF);
        wb_rd("rsvd_rd", A_RSVD, 32'h0);
        wb_xfer(1'b0, A_OTHER, '0, r, a);
        chk("nodecode_noack", 32'(a), 32'd0);

        // Change-only capture
        wb_wr("ctrl_en", A_CTRL, 32'h1);
        @(negedge clk); WB_OUT = 16'h0001;
        @(negedge clk); WB_OUT = 16'h0001;
        @(negedge clk); WB_OUT = 16'h0002;
        @(negedge clk); WB_OUT = 16'hBEEF;
        wb_rd("chg_status", A_STATUS, 32'h003);
        wb_rd("chg_data0", A_DATA, 32'h0001);
        wb_rd("chg_data1", A_DATA, 32'h0002);
        wb_rd("chg_data2", A_DATA, 32'hBEEF);
        wb_rd("chg_empty", A_STATUS, 32'h100);

        // Every-cycle capture into overflow, then W1C
        wb_wr("ctrl_every", A_CTRL, 32'h3);
        repeat (20) @(posedge clk);
        wb_rd("ovf_status", A_STATUS, 32'h610);
        wb_wr("ctrl_off", A_CTRL, 32'h0);
        wb_wr("ovf_w1c", A_STATUS, 32'h400);
        wb_rd("ovf_cleared", A_STATUS, 32'h210);

        // Pop coinciding with a push while full
        wb_rd("pp_pop1", A_DATA, 32'hBEEF);
        wb_rd("pp_cnt15", A_STATUS, 32'h00F);
        wb_wr("pp_ctrl_every", A_CTRL, 32'h3);
        wb_rd("pp_pop2", A_DATA, 32'hBEEF);
        chk("pp_count", 32'(dut.u_fifo.count), 32'd16);
        chk("pp_ovf", 32'(dut.ovf_q), 32'd0);
        wb_wr("pp_ctrl_off", A_CTRL, 32'h0);

        // Interrupt and clr
        wb_wr("clr_only", A_CTRL, 32'h8);
        wb_rd("clr_status", A_STATUS, 32'h100);
        wb_rd("clr_ctrl_rb", A_CTRL, 32'h0);
        wb_wr("ctrl_ie", A_CTRL, 32'h5);
        chk("irq_idle", 32'(irq_o), 32'd0);
        @(negedge clk); WB_OUT = 16'h1234;
        repeat (2) @(posedge clk); #1;
        chk("irq_rise", 32'(irq_o), 32'd1);
        wb_wr("ctrl_clr_ie", A_CTRL, 32'hD);
        chk("clr_count", 32'(dut.u_fifo.count), 32'd0);
        chk("irq_lag", 32'(irq_o), 32'd1);
        @(posedge clk); #1;
        chk("irq_fall", 32'(irq_o), 32'd0);
        wb_rd("ctrl_rb", A_CTRL, 32'h5);

        // Reset during an in-flight DATA read
        @(negedge clk); WB_OUT = 16'h5555;
        @(negedge clk); WB_OUT = 16'h6666;
        repeat (2) @(posedge clk); #1;
        chk("pre_rst_irq", 32'(irq_o), 32'd1);
        @(negedge clk);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
        @(posedge clk); #1;
        chk("inflight_ack", 32'(wbs_ack_o), 32'd1);
        RN = 1'b0;
        #1;
        chk("rst_ack_drop", 32'(wbs_ack_o), 32'd0);
        chk("rst_irq_drop", 32'(irq_o), 32'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge clk); RN = 1'b1;
        wb_rd("post_rst_status", A_STATUS, 32'h100);
        wb_rd("post_rst_ctrl", A_CTRL, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
